// File: rtl/pipeline_hazard_fwd.sv
// Hazard detection and operand forwarding unit for the pipelined 16-bit core.
// A small shift-register scoreboard tracks the destination of every in-flight
// producer (slot 0 = youngest). Each issued instruction's two source operands
// are resolved against it with youngest-producer priority. Loads that have not
// yet reached the slot where their data becomes valid cause a stall. Each stall
// injects a bubble into slot 0.
module pipeline_hazard_fwd #(
    parameter int DATA_W     = 16,
    parameter int REGN_W     = 3,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    issue_write,
    input  logic [REGN_W-1:0]       issue_wnum,
    input  logic                    issue_load,
    input  logic [1:0]              src_use,
    input  logic [REGN_W-1:0]       src_a_num,
    input  logic [REGN_W-1:0]       src_b_num,
    input  logic [DATA_W-1:0]       rf_a_data,
    input  logic [DATA_W-1:0]       rf_b_data,
    input  logic [DEPTH*DATA_W-1:0] stage_result,
    input  logic [DEPTH-1:0]        flush_mask,
    input  logic                    flush_issue,
    input  logic                    hold,
    output logic [DATA_W-1:0]       fwd_a_data,
    output logic [DATA_W-1:0]       fwd_b_data,
    output logic                    fwd_a_hit,
    output logic                    fwd_b_hit,
    output logic                    stall,
    output logic [DEPTH-1:0]        slot_valid,
    output logic [CNT_W-1:0]        stall_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  s_valid;
    logic [DEPTH-1:0]  s_write;
    logic [DEPTH-1:0]  s_load;
    logic [REGN_W-1:0] s_wnum [DEPTH];

    logic              a_found;
    logic              b_found;
    logic [IDX_W-1:0]  a_idx;
    logic [IDX_W-1:0]  b_idx;
    logic              a_not_ready;
    logic              b_not_ready;
    logic              take_issue;

    // Find the youngest matching producer for each operand. The scan runs
    // oldest to youngest so the lowest matching index is the one that sticks.
    always_comb begin
        a_found = 1'b0;
        a_idx   = '0;
        b_found = 1'b0;
        b_idx   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (s_valid[k] && s_write[k] && (s_wnum[k] == src_a_num)) begin
                a_found = 1'b1;
                a_idx   = IDX_W'(k);
            end
            if (s_valid[k] && s_write[k] && (s_wnum[k] == src_b_num)) begin
                b_found = 1'b1;
                b_idx   = IDX_W'(k);
            end
        end
    end

    assign fwd_a_hit   = src_use[0] & a_found;
    assign fwd_b_hit   = src_use[1] & b_found;
    assign fwd_a_data  = fwd_a_hit ? stage_result[int'(a_idx)*DATA_W +: DATA_W] : rf_a_data;
    assign fwd_b_data  = fwd_b_hit ? stage_result[int'(b_idx)*DATA_W +: DATA_W] : rf_b_data;

    // A load's data is only on stage_result from slot LOAD_READY onward.
    assign a_not_ready = fwd_a_hit & s_load[a_idx] & (int'(a_idx) < LOAD_READY);
    assign b_not_ready = fwd_b_hit & s_load[b_idx] & (int'(b_idx) < LOAD_READY);

    assign stall       = issue_valid & ~flush_issue & (a_not_ready | b_not_ready);
    assign take_issue  = issue_valid & ~stall & ~flush_issue;
    assign slot_valid  = s_valid & s_write;

    // Advance the scoreboard, or freeze it under hold. In both cases a flushed
    // slot is killed so its entry never shows up anywhere after the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_valid <= '0;
            s_write <= '0;
            s_load  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                s_wnum[k] <= '0;
            end
        end else if (hold) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (flush_mask[k]) begin
                    s_valid[k] <= 1'b0;
                    s_write[k] <= 1'b0;
                    s_load[k]  <= 1'b0;
                end
            end
        end else begin
            s_valid[0] <= take_issue;
            s_write[0] <= take_issue & issue_write;
            s_load[0]  <= take_issue & issue_load;
            s_wnum[0]  <= take_issue ? issue_wnum : '0;
            for (int k = 1; k < DEPTH; k++) begin
                s_valid[k] <= s_valid[k-1] & ~flush_mask[k-1];
                s_write[k] <= s_write[k-1] & ~flush_mask[k-1];
                s_load[k]  <= s_load[k-1] & ~flush_mask[k-1];
                s_wnum[k]  <= s_wnum[k-1];
            end
        end
    end

    // Count stalled cycles, holding at all-ones once it gets there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_fwd.sv
// Bench for pipeline_hazard_fwd. Two instances share all inputs: one uses the
// default parameters and the other a 2-bit stall counter to exercise saturation.
// At each checkpoint the expected outputs are queued when the stimulus is
// driven. They are popped and compared once the combinational outputs settle.
module tb_pipeline_hazard_fwd;

    localparam int DATA_W = 16;
    localparam int REGN_W = 3;
    localparam int DEPTH  = 3;

    logic                    clk;
    logic                    rst;
    logic                    issue_valid;
    logic                    issue_write;
    logic [REGN_W-1:0]       issue_wnum;
    logic                    issue_load;
    logic [1:0]              src_use;
    logic [REGN_W-1:0]       src_a_num;
    logic [REGN_W-1:0]       src_b_num;
    logic [DATA_W-1:0]       rf_a_data;
    logic [DATA_W-1:0]       rf_b_data;
    logic [DEPTH*DATA_W-1:0] stage_result;
    logic [DEPTH-1:0]        flush_mask;
    logic                    flush_issue;
    logic                    hold;

    logic [DATA_W-1:0]       fwd_a_data;
    logic [DATA_W-1:0]       fwd_b_data;
    logic                    fwd_a_hit;
    logic                    fwd_b_hit;
    logic                    stall;
    logic [DEPTH-1:0]        slot_valid;
    logic [15:0]             stall_cnt;

    logic [DATA_W-1:0]       sat_a_data;
    logic [DATA_W-1:0]       sat_b_data;
    logic                    sat_a_hit;
    logic                    sat_b_hit;
    logic                    sat_stall;
    logic [DEPTH-1:0]        sat_slot_valid;
    logic [1:0]              sat_cnt;

    typedef struct {
        string       tag;
        logic        stall;
        logic [2:0]  sv;
        logic        a_hit;
        logic [15:0] a_data;
        logic        b_hit;
        logic [15:0] b_data;
        logic [15:0] cnt;
        logic [1:0]  sat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    pipeline_hazard_fwd dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_write(issue_write),
        .issue_wnum(issue_wnum), .issue_load(issue_load), .src_use(src_use),
        .src_a_num(src_a_num), .src_b_num(src_b_num), .rf_a_data(rf_a_data),
        .rf_b_data(rf_b_data), .stage_result(stage_result), .flush_mask(flush_mask),
        .flush_issue(flush_issue), .hold(hold), .fwd_a_data(fwd_a_data),
        .fwd_b_data(fwd_b_data), .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .stall(stall), .slot_valid(slot_valid), .stall_cnt(stall_cnt)
    );

    pipeline_hazard_fwd #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_write(issue_write),
        .issue_wnum(issue_wnum), .issue_load(issue_load), .src_use(src_use),
        .src_a_num(src_a_num), .src_b_num(src_b_num), .rf_a_data(rf_a_data),
        .rf_b_data(rf_b_data), .stage_result(stage_result), .flush_mask(flush_mask),
        .flush_issue(flush_issue), .hold(hold), .fwd_a_data(sat_a_data),
        .fwd_b_data(sat_b_data), .fwd_a_hit(sat_a_hit), .fwd_b_hit(sat_b_hit),
        .stall(sat_stall), .slot_valid(sat_slot_valid), .stall_cnt(sat_cnt)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against the run getting stuck
    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout reached got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic exp_t mk(string tag, logic st, logic [2:0] sv, logic ah,
                                logic [15:0] ad, logic bh, logic [15:0] bd,
                                logic [15:0] cnt, logic [1:0] sat);
        exp_t r;
        r.tag = tag; r.stall = st; r.sv = sv; r.a_hit = ah; r.a_data = ad;
        r.b_hit = bh; r.b_data = bd; r.cnt = cnt; r.sat = sat;
        return r;
    endfunction

    task automatic set_idle();
        issue_valid = 1'b0; issue_write = 1'b0; issue_wnum = '0; issue_load = 1'b0;
        src_use = 2'b00; src_a_num = '0; src_b_num = '0;
        flush_mask = '0; flush_issue = 1'b0; hold = 1'b0;
    endtask

    task automatic set_issue(input logic w, input logic [2:0] wn, input logic ld,
                             input logic [1:0] u, input logic [2:0] a, input logic [2:0] b);
        set_idle();
        issue_valid = 1'b1; issue_write = w; issue_wnum = wn; issue_load = ld;
        src_use = u; src_a_num = a; src_b_num = b;
    endtask

    task automatic drain();
        set_idle();
        repeat (DEPTH) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_idle();
        src_use = 2'b11; src_a_num = 3'd1; src_b_num = 3'd2;
        rf_a_data = 16'hA0A0; rf_b_data = 16'hB0B0;
        stage_result = {16'h3333, 16'h2222, 16'h1111};
        exp_q.push_back(mk("reset", 1'b0, 3'b000, 1'b0, 16'hA0A0, 1'b0, 16'hB0B0, 16'd0, 2'd0));
        #2;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (fwd_a_hit !== e.a_hit) begin errors++; $display("[TB] FAIL %s a_hit got %0b want %0b", e.tag, fwd_a_hit, e.a_hit); end
        checks++; if (fwd_a_data !== e.a_data) begin errors++; $display("[TB] FAIL %s a_data got %h want %h", e.tag, fwd_a_data, e.a_data); end
        checks++; if (fwd_b_hit !== e.b_hit) begin errors++; $display("[TB] FAIL %s b_hit got %0b want %0b", e.tag, fwd_b_hit, e.b_hit); end
        checks++; if (fwd_b_data !== e.b_data) begin errors++; $display("[TB] FAIL %s b_data got %h want %h", e.tag, fwd_b_data, e.b_data); end
        checks++; if (stall_cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s stall_cnt got %0d want %0d", e.tag, stall_cnt, e.cnt); end
        checks++; if (sat_cnt !== e.sat) begin errors++; $display("[TB] FAIL %s sat_cnt got %0d want %0d", e.tag, sat_cnt, e.sat); end
        @(negedge clk);
        rst = 1'b1;
        set_idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        set_issue(1'b1, 3'd1, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk);
        set_issue(1'b0, 3'd0, 1'b0, 2'b01, 3'd1, 3'd0);
        stage_result = {16'h3333, 16'h2222, 16'h1234};
        exp_q.push_back(mk("b2b", 1'b0, 3'b001, 1'b1, 16'h1234, 1'b0, 16'hB0B0, 16'd0, 2'd0));
        #1;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (fwd_a_hit !== e.a_hit) begin errors++; $display("[TB] FAIL %s a_hit got %0b want %0b", e.tag, fwd_a_hit, e.a_hit); end
        checks++; if (fwd_a_data !== e.a_data) begin errors++; $display("[TB] FAIL %s a_data got %h want %h", e.tag, fwd_a_data, e.a_data); end
        checks++; if (fwd_b_hit !== e.b_hit) begin errors++; $display("[TB] FAIL %s b_hit got %0b want %0b", e.tag, fwd_b_hit, e.b_hit); end
        drain();
    endtask

    task automatic test_load_use();
        stage_result = {16'h3333, 16'h2222, 16'h1111};
        @(negedge clk);
        set_issue(1'b1, 3'd2, 1'b1, 2'b00, 3'd0, 3'd0);
        @(negedge clk);
        set_issue(1'b0, 3'd0, 1'b0, 2'b10, 3'd0, 3'd2);
        exp_q.push_back(mk("ld_use_c1", 1'b1, 3'b001, 1'b0, 16'h0, 1'b1, 16'h0, 16'd0, 2'd0));
        #1;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (fwd_b_hit !== e.b_hit) begin errors++; $display("[TB] FAIL %s b_hit got %0b want %0b", e.tag, fwd_b_hit, e.b_hit); end
        @(negedge clk);
        exp_q.push_back(mk("ld_use_c2", 1'b1, 3'b010, 1'b0, 16'h0, 1'b1, 16'h0, 16'd1, 2'd1));
        #1;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (stall_cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s stall_cnt got %0d want %0d", e.tag, stall_cnt, e.cnt); end
        @(negedge clk);
        exp_q.push_back(mk("ld_use_c3", 1'b0, 3'b100, 1'b0, 16'h0, 1'b1, 16'h3333, 16'd2, 2'd2));
        #1;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (fwd_b_hit !== e.b_hit) begin errors++; $display("[TB] FAIL %s b_hit got %0b want %0b", e.tag, fwd_b_hit, e.b_hit); end
        checks++; if (fwd_b_data !== e.b_data) begin errors++; $display("[TB] FAIL %s b_data got %h want %h", e.tag, fwd_b_data, e.b_data); end
        checks++; if (stall_cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s stall_cnt got %0d want %0d", e.tag, stall_cnt, e.cnt); end
        checks++; if (sat_cnt !== e.sat) begin errors++; $display("[TB] FAIL %s sat_cnt got %0d want %0d", e.tag, sat_cnt, e.sat); end
        drain();
    endtask

    task automatic test_priority();
        @(negedge clk); set_issue(1'b1, 3'd3, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk); set_issue(1'b1, 3'd5, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk); set_issue(1'b1, 3'd3, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk);
        set_issue(1'b0, 3'd0, 1'b0, 2'b11, 3'd3, 3'd5);
        stage_result = {16'h5555, 16'h7777, 16'hAAAA};
        exp_q.push_back(mk("youngest", 1'b0, 3'b111, 1'b1, 16'hAAAA, 1'b1, 16'h7777, 16'd2, 2'd2));
        #1;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (fwd_a_data !== e.a_data) begin errors++; $display("[TB] FAIL %s a_data got %h want %h", e.tag, fwd_a_data, e.a_data); end
        checks++; if (fwd_b_data !== e.b_data) begin errors++; $display("[TB] FAIL %s b_data got %h want %h", e.tag, fwd_b_data, e.b_data); end
        drain();
        @(negedge clk); set_issue(1'b1, 3'd6, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk); set_issue(1'b1, 3'd6, 1'b1, 2'b00, 3'd0, 3'd0);
        @(negedge clk);
        set_issue(1'b0, 3'd0, 1'b0, 2'b01, 3'd6, 3'd0);
        exp_q.push_back(mk("young_load", 1'b1, 3'b011, 1'b1, 16'h0, 1'b0, 16'h0, 16'd2, 2'd2));
        #1;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (fwd_a_hit !== e.a_hit) begin errors++; $display("[TB] FAIL %s a_hit got %0b want %0b", e.tag, fwd_a_hit, e.a_hit); end
        drain();
    endtask

    task automatic test_flush();
        stage_result = {16'h3333, 16'h2222, 16'h1111};
        @(negedge clk); set_issue(1'b1, 3'd4, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk); set_idle(); flush_mask = 3'b001;
        exp_q.push_back(mk("flush_pre", 1'b0, 3'b001, 1'b0, 16'h0, 1'b0, 16'h0, 16'd2, 2'd2));
        #1;
        e = exp_q.pop_front();
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        @(negedge clk);
        set_issue(1'b0, 3'd0, 1'b0, 2'b01, 3'd4, 3'd0);
        exp_q.push_back(mk("flush_post", 1'b0, 3'b000, 1'b0, 16'hA0A0, 1'b0, 16'h0, 16'd2, 2'd2));
        #1;
        e = exp_q.pop_front();
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (fwd_a_hit !== e.a_hit) begin errors++; $display("[TB] FAIL %s a_hit got %0b want %0b", e.tag, fwd_a_hit, e.a_hit); end
        checks++; if (fwd_a_data !== e.a_data) begin errors++; $display("[TB] FAIL %s a_data got %h want %h", e.tag, fwd_a_data, e.a_data); end
        @(negedge clk); set_issue(1'b1, 3'd7, 1'b0, 2'b00, 3'd0, 3'd0); flush_issue = 1'b1;
        @(negedge clk);
        set_issue(1'b0, 3'd0, 1'b0, 2'b01, 3'd7, 3'd0);
        exp_q.push_back(mk("flush_issue", 1'b0, 3'b000, 1'b0, 16'hA0A0, 1'b0, 16'h0, 16'd2, 2'd2));
        #1;
        e = exp_q.pop_front();
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (fwd_a_hit !== e.a_hit) begin errors++; $display("[TB] FAIL %s a_hit got %0b want %0b", e.tag, fwd_a_hit, e.a_hit); end
        @(negedge clk); set_issue(1'b1, 3'd2, 1'b1, 2'b00, 3'd0, 3'd0);
        @(negedge clk);
        set_issue(1'b0, 3'd0, 1'b0, 2'b10, 3'd0, 3'd2); flush_issue = 1'b1;
        exp_q.push_back(mk("flush_no_stall", 1'b0, 3'b001, 1'b0, 16'h0, 1'b1, 16'h0, 16'd2, 2'd2));
        #1;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (fwd_b_hit !== e.b_hit) begin errors++; $display("[TB] FAIL %s b_hit got %0b want %0b", e.tag, fwd_b_hit, e.b_hit); end
        set_idle();
        @(negedge clk); set_issue(1'b1, 3'd1, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk); set_issue(1'b1, 3'd2, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk); set_idle(); flush_mask = 3'b010;
        @(negedge clk); set_idle();
        exp_q.push_back(mk("flush_mid", 1'b0, 3'b010, 1'b0, 16'h0, 1'b0, 16'h0, 16'd2, 2'd2));
        #1;
        e = exp_q.pop_front();
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        drain();
    endtask

    task automatic test_hold();
        stage_result = {16'h3333, 16'h2222, 16'h1111};
        @(negedge clk); set_issue(1'b1, 3'd5, 1'b1, 2'b00, 3'd0, 3'd0);
        @(negedge clk);
        set_issue(1'b0, 3'd0, 1'b0, 2'b01, 3'd5, 3'd0); hold = 1'b1;
        exp_q.push_back(mk("hold_enter", 1'b1, 3'b001, 1'b0, 16'h0, 1'b0, 16'h0, 16'd2, 2'd2));
        #1;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            exp_q.push_back(mk($sformatf("hold_%0d", i), 1'b1, 3'b001, 1'b0, 16'h0, 1'b0, 16'h0,
                               16'(2 + i), 2'd3));
            #1;
            e = exp_q.pop_front();
            checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
            checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
            checks++; if (stall_cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s stall_cnt got %0d want %0d", e.tag, stall_cnt, e.cnt); end
            checks++; if (sat_cnt !== e.sat) begin errors++; $display("[TB] FAIL %s sat_cnt got %0d want %0d", e.tag, sat_cnt, e.sat); end
        end
        hold = 1'b0;
        @(negedge clk);
        exp_q.push_back(mk("hold_release", 1'b1, 3'b010, 1'b0, 16'h0, 1'b0, 16'h0, 16'd6, 2'd3));
        #1;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (stall_cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s stall_cnt got %0d want %0d", e.tag, stall_cnt, e.cnt); end
        @(negedge clk);
        exp_q.push_back(mk("hold_ready", 1'b0, 3'b100, 1'b1, 16'h3333, 1'b0, 16'h0, 16'd7, 2'd3));
        #1;
        e = exp_q.pop_front();
        checks++; if (stall !== e.stall) begin errors++; $display("[TB] FAIL %s stall got %0b want %0b", e.tag, stall, e.stall); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (fwd_a_data !== e.a_data) begin errors++; $display("[TB] FAIL %s a_data got %h want %h", e.tag, fwd_a_data, e.a_data); end
        checks++; if (stall_cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s stall_cnt got %0d want %0d", e.tag, stall_cnt, e.cnt); end
        checks++; if (sat_cnt !== e.sat) begin errors++; $display("[TB] FAIL %s sat_cnt got %0d want %0d", e.tag, sat_cnt, e.sat); end
        drain();
        @(negedge clk); set_issue(1'b1, 3'd1, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk); set_idle(); hold = 1'b1; flush_mask = 3'b001;
        @(negedge clk); set_idle(); hold = 1'b1;
        exp_q.push_back(mk("hold_flush", 1'b0, 3'b000, 1'b0, 16'h0, 1'b0, 16'h0, 16'd7, 2'd3));
        #1;
        e = exp_q.pop_front();
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        set_idle();
    endtask

    task automatic test_async_reset();
        @(negedge clk); set_issue(1'b1, 3'd1, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk); set_issue(1'b1, 3'd2, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk); set_issue(1'b1, 3'd3, 1'b0, 2'b00, 3'd0, 3'd0);
        @(negedge clk); set_idle();
        exp_q.push_back(mk("full", 1'b0, 3'b111, 1'b0, 16'h0, 1'b0, 16'h0, 16'd7, 2'd3));
        #1;
        e = exp_q.pop_front();
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (stall_cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s stall_cnt got %0d want %0d", e.tag, stall_cnt, e.cnt); end
        #2;
        rst = 1'b0;
        exp_q.push_back(mk("async_rst", 1'b0, 3'b000, 1'b0, 16'h0, 1'b0, 16'h0, 16'd0, 2'd0));
        #1;
        e = exp_q.pop_front();
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        checks++; if (stall_cnt !== e.cnt) begin errors++; $display("[TB] FAIL %s stall_cnt got %0d want %0d", e.tag, stall_cnt, e.cnt); end
        checks++; if (sat_cnt !== e.sat) begin errors++; $display("[TB] FAIL %s sat_cnt got %0d want %0d", e.tag, sat_cnt, e.sat); end
        @(negedge clk);
        rst = 1'b1;
        set_issue(1'b0, 3'd0, 1'b0, 2'b01, 3'd1, 3'd0);
        @(negedge clk);
        exp_q.push_back(mk("post_rst", 1'b0, 3'b000, 1'b0, 16'hA0A0, 1'b0, 16'h0, 16'd0, 2'd0));
        #1;
        e = exp_q.pop_front();
        checks++; if (fwd_a_hit !== e.a_hit) begin errors++; $display("[TB] FAIL %s a_hit got %0b want %0b", e.tag, fwd_a_hit, e.a_hit); end
        checks++; if (fwd_a_data !== e.a_data) begin errors++; $display("[TB] FAIL %s a_data got %h want %h", e.tag, fwd_a_data, e.a_data); end
        checks++; if (slot_valid !== e.sv) begin errors++; $display("[TB] FAIL %s slot_valid got %b want %b", e.tag, slot_valid, e.sv); end
        set_idle();
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_priority();
        test_flush();
        test_hold();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
